// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands in a small FIFO, issues them one at a
// time to the 16-bit ALU, waits SETTLE cycles, then registers the result.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready = room in FIFO)
//   cmd_op, cmd_a, cmd_b, cmd_flag command payload
//   alu_sel, alu_opa, alu_opb,     registered drive to the ALU inputs
//   alu_flag
//   alu_y1, alu_y2, alu_y3,        ALU results sampled at capture
//   alu_cout, alu_carry_out
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_carry, rsp_op    captured result, carry flag and opcode
//   busy                           command in flight or FIFO non-empty
//   count                          FIFO occupancy
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [15:0]              cmd_a,
  input  logic [15:0]              cmd_b,
  input  logic                     cmd_flag,
  output logic [1:0]               alu_sel,
  output logic [15:0]              alu_opa,
  output logic [15:0]              alu_opb,
  output logic                     alu_flag,
  input  logic [15:0]              alu_y1,
  input  logic [31:0]              alu_y2,
  input  logic [15:0]              alu_y3,
  input  logic                     alu_cout,
  input  logic                     alu_carry_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_carry,
  output logic [1:0]               rsp_op,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = 4;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        flag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  cmd_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  state_t          state, state_n;
  logic [SW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   count_n;
  logic            push, pop, busy_n;
  cmd_t            head;
  logic [1:0]      alu_sel_n, rsp_op_n;
  logic [15:0]     alu_opa_n, alu_opb_n;
  logic            alu_flag_n, rsp_valid_n, rsp_carry_n;
  logic [31:0]     rsp_data_n;

  // Ready depends only on registered occupancy and reset; never on a same-cycle pop.
  assign cmd_ready = !rst && (count < CW'(DEPTH));

  // FIFO storage; no reset needed since pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_t'{cmd_op, cmd_a, cmd_b, cmd_flag};
  end

  // Next-state and next-output logic.
  always_comb begin
    push        = cmd_valid && cmd_ready;
    pop         = 1'b0;
    state_n     = state;
    cnt_n       = cnt;
    alu_sel_n   = alu_sel;
    alu_opa_n   = alu_opa;
    alu_opb_n   = alu_opb;
    alu_flag_n  = alu_flag;
    rsp_valid_n = rsp_valid;
    rsp_data_n  = rsp_data;
    rsp_carry_n = rsp_carry;
    rsp_op_n    = rsp_op;
    head        = mem[rd_ptr];

    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          alu_sel_n  = head.op;
          alu_opa_n  = head.a;
          alu_opb_n  = head.b;
          alu_flag_n = head.flag;
          cnt_n      = SW'(SETTLE - 1);
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - SW'(1);
        end else begin
          rsp_valid_n = 1'b1;
          rsp_op_n    = alu_sel;
          case (alu_sel)
            2'b00:   begin rsp_data_n = {16'h0, alu_y1}; rsp_carry_n = alu_cout;      end
            2'b01:   begin rsp_data_n = {16'h0, alu_y1}; rsp_carry_n = alu_carry_out; end
            2'b10:   begin rsp_data_n = alu_y2;          rsp_carry_n = 1'b0;          end
            default: begin rsp_data_n = {alu_y3, alu_y1}; rsp_carry_n = 1'b0;         end
          endcase
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    count_n = count + CW'(push) - CW'(pop);
    // Registered busy computed from next values so it tracks state/count exactly.
    busy_n  = (state_n != IDLE) || (count_n != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      busy      <= 1'b0;
      alu_sel   <= '0;
      alu_opa   <= '0;
      alu_opb   <= '0;
      alu_flag  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_op    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_n;
      busy      <= busy_n;
      alu_sel   <= alu_sel_n;
      alu_opa   <= alu_opa_n;
      alu_opb   <= alu_opb_n;
      alu_flag  <= alu_flag_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      rsp_carry <= rsp_carry_n;
      rsp_op    <= rsp_op_n;
    end
  end

endmodule
